// File: rtl/dac_stream_pkg.sv
// ---------------------------------------------------------------------------
// dac_stream_pkg
// Shared defaults for the DAC sample streamer and the rate-divider helper.
// ---------------------------------------------------------------------------
package dac_stream_pkg;

    localparam int DATA_WIDTH_DEF = 10;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int DIV_WIDTH_DEF  = 16;

    // A programmed divider of 0 would give a 1-clock period with no room for
    // a data-clock high phase, so it is promoted to 1 (2-clock period).
    function automatic int unsigned eff_div(input int unsigned div);
        return (div == 0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/dac_sync_fifo.sv
// ---------------------------------------------------------------------------
// dac_sync_fifo
// Single-clock sample FIFO with push, pop and flush. Occupancy is tracked in
// its own counter so full and empty are unambiguous.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_data    push request and sample (bit 0 is MSB)
//   i_pop             pop request (ignored when empty)
//   i_flush           drop all contents; beats push and pop
//   o_head            entry at the read pointer
//   o_pop_ok          pop is taking effect this cycle
//   o_push_drop       push refused because the FIFO is full
//   o_level, o_full, o_empty   occupancy status
// ---------------------------------------------------------------------------
module dac_sync_fifo
    import dac_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [0:DATA_WIDTH-1] i_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [0:DATA_WIDTH-1] o_head,
    output logic                  o_pop_ok,
    output logic                  o_push_drop,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_MAX = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    logic [0:DATA_WIDTH-1]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_level;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_level == LVL_MAX);
    assign w_empty   = (r_level == '0);
    assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = i_push & ~i_flush & (~w_full | w_pop_ok);

    // Storage is deliberately left unreset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_level <= r_level + LVL_ONE;
            end else if (w_pop_ok && !w_push_ok) begin
                r_level <= r_level - LVL_ONE;
            end
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_pop_ok    = w_pop_ok;
    assign o_push_drop = i_push & ~i_flush & w_full & ~w_pop_ok;
    assign o_level     = r_level;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

endmodule

// File: rtl/dac_sample_streamer.sv
// ---------------------------------------------------------------------------
// dac_sample_streamer
// Buffers samples written over the bus and releases one to the DAC every
// D+1 clocks (D = effective divider), together with a data clock whose
// rising edge falls mid-sample. Reports FIFO level and sticky
// overflow/underrun flags.
//
// Ports:
//   Bus2IP_Clk, Bus2IP_Reset   clock, synchronous active-high reset
//   smp_wr, smp_data           sample push strobe and data (bit 0 is MSB)
//   ctl_enable                 1 = streaming, 0 = paused
//   ctl_div                    output period minus one (0 treated as 1)
//   ctl_flush                  empty the FIFO
//   sts_clr                    clear sticky flags
//   dac_data, dac_dclk         registered DAC bus and data clock
//   fifo_level/full/empty      FIFO occupancy
//   sts_overflow/underrun      sticky error flags
// ---------------------------------------------------------------------------
module dac_sample_streamer
    import dac_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
    input  logic                  Bus2IP_Clk,
    input  logic                  Bus2IP_Reset,
    input  logic                  smp_wr,
    input  logic [0:DATA_WIDTH-1] smp_data,
    input  logic                  ctl_enable,
    input  logic [DIV_WIDTH-1:0]  ctl_div,
    input  logic                  ctl_flush,
    input  logic                  sts_clr,
    output logic [0:DATA_WIDTH-1] dac_data,
    output logic                  dac_dclk,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  sts_overflow,
    output logic                  sts_underrun
);

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = 1;

    logic [DIV_WIDTH-1:0]  r_cnt;
    logic                  r_dclk;
    logic [0:DATA_WIDTH-1] r_dac_data;
    logic                  r_overflow;
    logic                  r_underrun;

    logic [DIV_WIDTH-1:0]  w_div_eff;
    logic                  w_tick;
    logic [0:DATA_WIDTH-1] w_head;
    logic                  w_pop_ok;
    logic                  w_push_drop;
    logic                  w_empty;
    logic                  w_underrun_evt;

    assign w_div_eff = DIV_WIDTH'(eff_div(32'(ctl_div)));
    assign w_tick    = ctl_enable & (r_cnt == w_div_eff);

    dac_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk       (Bus2IP_Clk),
        .i_rst       (Bus2IP_Reset),
        .i_push      (smp_wr),
        .i_data      (smp_data),
        .i_pop       (w_tick),
        .i_flush     (ctl_flush),
        .o_head      (w_head),
        .o_pop_ok    (w_pop_ok),
        .o_push_drop (w_push_drop),
        .o_level     (fifo_level),
        .o_full      (fifo_full),
        .o_empty     (w_empty)
    );

    assign w_underrun_evt = w_tick & w_empty;

    // Rate counter and data clock. The counter wraps at DIV_WIDTH if the
    // divider is lowered below the current count while running.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_cnt  <= '0;
            r_dclk <= 1'b0;
        end else if (!ctl_enable) begin
            r_cnt  <= '0;
            r_dclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_dclk <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == (w_div_eff >> 1)) begin
                r_dclk <= 1'b1;
            end
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_dac_data <= '0;
        end else if (w_pop_ok) begin
            r_dac_data <= w_head;
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end else if (sts_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_underrun_evt) begin
                r_underrun <= 1'b1;
            end else if (sts_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign dac_data     = r_dac_data;
    assign dac_dclk     = r_dclk;
    assign fifo_empty   = w_empty;
    assign sts_overflow = r_overflow;
    assign sts_underrun = r_underrun;

endmodule

// File: tb/tb_dac_sample_streamer.sv
module tb_dac_sample_streamer;

    logic        clk;
    logic        rst;
    logic        smp_wr;
    logic [0:9]  smp_data;
    logic        ctl_enable;
    logic [15:0] ctl_div;
    logic        ctl_flush;
    logic        sts_clr;
    logic [0:9]  dac_data;
    logic        dac_dclk;
    logic [4:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_empty;
    logic        sts_overflow;
    logic        sts_underrun;

    int n_assert = 0;
    int n_fail   = 0;

    dac_sample_streamer dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .smp_wr       (smp_wr),
        .smp_data     (smp_data),
        .ctl_enable   (ctl_enable),
        .ctl_div      (ctl_div),
        .ctl_flush    (ctl_flush),
        .sts_clr      (sts_clr),
        .dac_data     (dac_data),
        .dac_dclk     (dac_dclk),
        .fifo_level   (fifo_level),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .sts_overflow (sts_overflow),
        .sts_underrun (sts_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then observed 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [0:9] v);
        smp_wr   = 1'b1;
        smp_data = v;
        cyc();
        smp_wr   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; smp_wr = 1'b0; smp_data = '0; ctl_enable = 1'b0;
        ctl_div = '0; ctl_flush = 1'b0; sts_clr = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        n_assert++; if (dac_data !== 10'h000) begin n_fail++; $display("FAIL reset_data got %h exp 000", dac_data); end
        n_assert++; if (dac_dclk !== 1'b0) begin n_fail++; $display("FAIL reset_dclk got %b exp 0", dac_dclk); end
        n_assert++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
        n_assert++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", fifo_full); end
        n_assert++; if (sts_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", sts_overflow); end
        n_assert++; if (sts_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_und got %b exp 0", sts_underrun); end
    endtask

    task automatic test_stream();
        logic [0:9] exp_d [3];
        logic [3:0] pat;
        logic [0:9] prev;
        exp_d = '{10'h3FF, 10'h001, 10'h2AA};
        pat   = 4'b0110;
        prev  = 10'h000;
        for (int i = 0; i < 3; i++) push(exp_d[i]);
        n_assert++; if (fifo_level !== 5'd3) begin n_fail++; $display("FAIL stream_level0 got %0d exp 3", fifo_level); end
        ctl_div = 16'd3;
        ctl_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                cyc();
                n_assert++; if (dac_dclk !== pat[j]) begin n_fail++; $display("FAIL stream_dclk s%0d c%0d got %b exp %b", k, j, dac_dclk, pat[j]); end
                if (j == 0) begin
                    n_assert++; if (dac_data !== prev) begin n_fail++; $display("FAIL stream_hold s%0d got %h exp %h", k, dac_data, prev); end
                end
                if (j == 3) begin
                    n_assert++; if (dac_data !== exp_d[k]) begin n_fail++; $display("FAIL stream_data s%0d got %h exp %h", k, dac_data, exp_d[k]); end
                    n_assert++; if (fifo_level !== 5'(2 - k)) begin n_fail++; $display("FAIL stream_level s%0d got %0d exp %0d", k, fifo_level, 2 - k); end
                end
            end
            prev = exp_d[k];
        end
        ctl_enable = 1'b0;
        cyc();
        n_assert++; if (sts_overflow !== 1'b0) begin n_fail++; $display("FAIL stream_ovf got %b exp 0", sts_overflow); end
        n_assert++; if (sts_underrun !== 1'b0) begin n_fail++; $display("FAIL stream_und got %b exp 0", sts_underrun); end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty got %b exp 1", fifo_empty); end
    endtask

    task automatic test_div0();
        logic [3:0] pat;
        pat = 4'b0101;
        push(10'h155);
        ctl_div = 16'd0;
        ctl_enable = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            n_assert++; if (dac_dclk !== pat[j]) begin n_fail++; $display("FAIL div0_dclk c%0d got %b exp %b", j, dac_dclk, pat[j]); end
            if (j == 1) begin
                n_assert++; if (dac_data !== 10'h155) begin n_fail++; $display("FAIL div0_data got %h exp 155", dac_data); end
                n_assert++; if (sts_underrun !== 1'b0) begin n_fail++; $display("FAIL div0_und_early got %b exp 0", sts_underrun); end
            end
        end
        n_assert++; if (sts_underrun !== 1'b1) begin n_fail++; $display("FAIL div0_und got %b exp 1", sts_underrun); end
        n_assert++; if (dac_data !== 10'h155) begin n_fail++; $display("FAIL div0_hold got %h exp 155", dac_data); end
        ctl_enable = 1'b0;
        cyc();
        sts_clr = 1'b1; cyc(); sts_clr = 1'b0;
        n_assert++; if (sts_underrun !== 1'b0) begin n_fail++; $display("FAIL div0_clr got %b exp 0", sts_underrun); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push(10'(10'h100 + i));
        n_assert++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level16 got %0d exp 16", fifo_level); end
        n_assert++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b exp 1", fifo_full); end
        n_assert++; if (sts_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", sts_overflow); end
        push(10'h3AB);
        n_assert++; if (sts_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", sts_overflow); end
        n_assert++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL ovf_level17 got %0d exp 16", fifo_level); end
        sts_clr = 1'b1; cyc(); sts_clr = 1'b0;
        n_assert++; if (sts_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got %b exp 0", sts_overflow); end
    endtask

    task automatic test_full_simul();
        ctl_div = 16'd1;
        ctl_enable = 1'b1;
        cyc();
        smp_wr = 1'b1; smp_data = 10'h3C3;
        cyc();
        smp_wr = 1'b0;
        n_assert++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL fullsim_level got %0d exp 16", fifo_level); end
        n_assert++; if (sts_overflow !== 1'b0) begin n_fail++; $display("FAIL fullsim_ovf got %b exp 0", sts_overflow); end
        n_assert++; if (dac_data !== 10'h100) begin n_fail++; $display("FAIL fullsim_data got %h exp 100", dac_data); end
        ctl_enable = 1'b0;
        cyc();
    endtask

    task automatic test_empty_simul();
        ctl_flush = 1'b1; cyc(); ctl_flush = 1'b0;
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL emptysim_flush got %b exp 1", fifo_empty); end
        ctl_div = 16'd1;
        ctl_enable = 1'b1;
        cyc();
        smp_wr = 1'b1; smp_data = 10'h0F0;
        cyc();
        smp_wr = 1'b0;
        n_assert++; if (sts_underrun !== 1'b1) begin n_fail++; $display("FAIL emptysim_und got %b exp 1", sts_underrun); end
        n_assert++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL emptysim_level got %0d exp 1", fifo_level); end
        n_assert++; if (dac_data !== 10'h100) begin n_fail++; $display("FAIL emptysim_hold got %h exp 100", dac_data); end
        cyc();
        cyc();
        n_assert++; if (dac_data !== 10'h0F0) begin n_fail++; $display("FAIL emptysim_out got %h exp 0F0", dac_data); end
        n_assert++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL emptysim_drain got %0d exp 0", fifo_level); end
        ctl_enable = 1'b0;
        cyc();
        sts_clr = 1'b1; cyc(); sts_clr = 1'b0;
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 5; i++) push(10'(10'h050 + i));
        n_assert++; if (fifo_level !== 5'd5) begin n_fail++; $display("FAIL flush_pre got %0d exp 5", fifo_level); end
        ctl_flush = 1'b1; smp_wr = 1'b1; smp_data = 10'h222;
        cyc();
        ctl_flush = 1'b0; smp_wr = 1'b0;
        n_assert++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL flush_level got %0d exp 0", fifo_level); end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b exp 1", fifo_empty); end
        n_assert++; if (sts_overflow !== 1'b0) begin n_fail++; $display("FAIL flush_ovf got %b exp 0", sts_overflow); end
        n_assert++; if (dac_data !== 10'h0F0) begin n_fail++; $display("FAIL flush_hold got %h exp 0F0", dac_data); end
        push(10'h011);
        push(10'h022);
        ctl_div = 16'd3;
        ctl_enable = 1'b1;
        cyc(); cyc();
        n_assert++; if (dac_dclk !== 1'b1) begin n_fail++; $display("FAIL midrun_dclk got %b exp 1", dac_dclk); end
        rst = 1'b1; smp_wr = 1'b1; smp_data = 10'h333;
        cyc();
        rst = 1'b0; smp_wr = 1'b0; ctl_enable = 1'b0;
        n_assert++; if (dac_data !== 10'h000) begin n_fail++; $display("FAIL rst2_data got %h exp 000", dac_data); end
        n_assert++; if (dac_dclk !== 1'b0) begin n_fail++; $display("FAIL rst2_dclk got %b exp 0", dac_dclk); end
        n_assert++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL rst2_level got %0d exp 0", fifo_level); end
        n_assert++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rst2_empty got %b exp 1", fifo_empty); end
        n_assert++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst2_full got %b exp 0", fifo_full); end
        n_assert++; if (sts_overflow !== 1'b0) begin n_fail++; $display("FAIL rst2_ovf got %b exp 0", sts_overflow); end
        n_assert++; if (sts_underrun !== 1'b0) begin n_fail++; $display("FAIL rst2_und got %b exp 0", sts_underrun); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_div0();
        test_overflow();
        test_full_simul();
        test_empty_simul();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
